// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
//
// Purpose:
//   Sequencer for the PUSH / POP / CALL / RET micro-operations. Each operation
//   reads the stack pointer (register 31) from the register bank and performs
//   one data-memory access. It then writes the updated SP back in a single
//   write-back cycle. POP also writes the popped word into a general register.
//   RET hands the popped word to the fetch unit as a new PC.
//   The stack grows downward from STACK_BASE.
//
// Configuration:
//   STACK_BOUNDS_CHECK_EN - when defined, push-class operations that would
//   take SP below STACK_LIMIT and pop-class operations on an empty stack
//   (SP >= STACK_BASE) are rejected with an err/done pulse and no side
//   effects. When undefined, err stays 0 and SP wraps modulo 2^DATA_W.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   op_valid, op, op_ready     operation request handshake (accept in IDLE)
//   push_data, pc_in, dr_in    PUSH word, CALL return address, POP target reg
//   readSP, sp_in              SP read select / register-bank read data
//   writeSP, write_dataSP      SP write strobe and new SP value
//   writeReg, dr, write_data   general-register write port (POP)
//   pc_load, pc_target         PC redirect strobe and target (RET)
//   mem_re, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ready                  data-memory port, held until mem_ready
//   done, err                  completion pulse, overflow/underflow pulse
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] STACK_BASE  = DATA_W'(32'h0000_1000),
  parameter logic [DATA_W-1:0] STACK_LIMIT = DATA_W'(32'h0000_0800)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op,
  output logic              op_ready,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [4:0]        dr_in,
  output logic              readSP,
  input  logic [DATA_W-1:0] sp_in,
  output logic              writeSP,
  output logic [DATA_W-1:0] write_dataSP,
  output logic              writeReg,
  output logic [4:0]        dr,
  output logic [DATA_W-1:0] write_data,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_target,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_SP = 2'd1,
    MEM   = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [DATA_W-1:0] WORD_BYTES = DATA_W'(4);

`ifdef STACK_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [4:0]        dr_q, dr_d;
  logic [DATA_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] new_sp_q, new_sp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              push_class;
  logic [DATA_W-1:0] sp_dec;
  logic [DATA_W-1:0] sp_inc;
  logic              bounds_err;

  // PUSH (00) and CALL (10) share op bit 0 = 0; POP and RET have it set.
  assign push_class = ~op_q[0];

  assign sp_dec = sp_in - WORD_BYTES;
  assign sp_inc = sp_in + WORD_BYTES;

  // The limit test uses the wrapped (modulo) decrement, as the datapath does.
  assign bounds_err = CHECK_EN & (push_class ? (sp_dec < STACK_LIMIT)
                                             : (sp_in >= STACK_BASE));

  // State and operand registers. The err pulse is registered so it lands in
  // the cycle after RD_SP, in line with the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_PUSH;
      word_q   <= '0;
      dr_q     <= '0;
      sp_q     <= '0;
      new_sp_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      word_q   <= word_d;
      dr_q     <= dr_d;
      sp_q     <= sp_d;
      new_sp_q <= new_sp_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state and operand capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    word_d   = word_q;
    dr_d     = dr_q;
    sp_d     = sp_q;
    new_sp_d = new_sp_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d    = op;
          // CALL pushes the return address; every other op uses push_data.
          word_d  = (op == OP_CALL) ? pc_in : push_data;
          dr_d    = dr_in;
          state_d = RD_SP;
        end
      end
      RD_SP: begin
        sp_d     = sp_in;
        new_sp_d = push_class ? sp_dec : sp_inc;
        if (bounds_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = MEM;
        end
      end
      MEM: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from state and registers only, so reset clears them
  // at once and op_valid never reaches the memory port combinationally.
  always_comb begin
    op_ready     = (state_q == IDLE);
    readSP       = (state_q == RD_SP);

    // A push writes at the decremented SP; a pop reads at the current SP.
    mem_we       = (state_q == MEM) &  push_class;
    mem_re       = (state_q == MEM) & ~push_class;
    mem_addr     = '0;
    if (state_q == MEM) begin
      mem_addr   = push_class ? new_sp_q : sp_q;
    end
    mem_wdata    = mem_we ? word_q : '0;

    writeSP      = (state_q == WB);
    write_dataSP = writeSP ? new_sp_q : '0;
    writeReg     = (state_q == WB) & (op_q == OP_POP);
    dr           = writeReg ? dr_q : '0;
    write_data   = writeReg ? rdata_q : '0;
    pc_load      = (state_q == WB) & (op_q == OP_RET);
    pc_target    = pc_load ? rdata_q : '0;

    done         = (state_q == WB) | err_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
//
// Directed bench for stack_ctrl. Stimulus pushes the expected memory request
// and write-back (or error) events into a queue. A monitor compares each
// memory-request cycle and each done pulse against the head of that queue.
// A small memory model answers requests after a per-operation wait count.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op;
  logic        op_ready;
  logic [31:0] push_data;
  logic [31:0] pc_in;
  logic [4:0]  dr_in;
  logic        readSP;
  logic [31:0] sp_in;
  logic        writeSP;
  logic [31:0] write_dataSP;
  logic        writeReg;
  logic [4:0]  dr;
  logic [31:0] write_data;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        done;
  logic        err;

  stack_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op           (op),
    .op_ready     (op_ready),
    .push_data    (push_data),
    .pc_in        (pc_in),
    .dr_in        (dr_in),
    .readSP       (readSP),
    .sp_in        (sp_in),
    .writeSP      (writeSP),
    .write_dataSP (write_dataSP),
    .writeReg     (writeReg),
    .dr           (dr),
    .write_data   (write_data),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .done         (done),
    .err          (err)
  );

  typedef struct {
    logic        isWb;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wSp;
    logic [31:0] spVal;
    logic        wReg;
    logic [4:0]  dr;
    logic [31:0] wData;
    logic        pcLoad;
    logic [31:0] pcTgt;
    logic        err;
    int          lat;
  } expT;

  expT expQ[$];

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  int acceptCycle = 0;
  int memWait = 0;

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cycleCnt++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  function automatic expT makeMem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    expT e;
    e = '{default: '0};
    e.isWb  = 1'b0;
    e.we    = we;
    e.re    = ~we;
    e.addr  = addr;
    e.wdata = wdata;
    return e;
  endfunction

  function automatic expT makeWb(input logic wSp, input logic [31:0] spVal, input logic wReg,
                                 input logic [4:0] d, input logic [31:0] wData, input logic pcLoad,
                                 input logic [31:0] pcTgt, input logic e_err, input int lat);
    expT e;
    e = '{default: '0};
    e.isWb   = 1'b1;
    e.wSp    = wSp;
    e.spVal  = spVal;
    e.wReg   = wReg;
    e.dr     = d;
    e.wData  = wData;
    e.pcLoad = pcLoad;
    e.pcTgt  = pcTgt;
    e.err    = e_err;
    e.lat    = lat;
    return e;
  endfunction

  // Memory model: answers a request after memWait cycles of waiting.
  initial begin
    int reqCycles;
    reqCycles = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_re || mem_we) begin
        mem_ready = (reqCycles == memWait);
        reqCycles++;
      end else begin
        mem_ready = 1'b0;
        reqCycles = 0;
      end
    end
  end

  // Monitor: every request cycle must match the queued memory event (which
  // also proves the request is held stable); every done pulse must match the
  // queued write-back or error event.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_re || mem_we) begin
          if (expQ.size() == 0 || expQ[0].isWb) begin
            checkOutput("unexpectedMemReq", 32'({mem_we, mem_re}), 32'd0);
          end else begin
            e = expQ[0];
            checkOutput("memWe", 32'(mem_we), 32'(e.we));
            checkOutput("memRe", 32'(mem_re), 32'(e.re));
            checkOutput("memAddr", mem_addr, e.addr);
            if (e.we) checkOutput("memWdata", mem_wdata, e.wdata);
            if (mem_ready) void'(expQ.pop_front());
          end
        end
        if (done) begin
          if (expQ.size() == 0 || !expQ[0].isWb) begin
            checkOutput("unexpectedDone", 32'(done), 32'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("writeSP", 32'(writeSP), 32'(e.wSp));
            checkOutput("writeDataSP", write_dataSP, e.spVal);
            checkOutput("writeReg", 32'(writeReg), 32'(e.wReg));
            checkOutput("dr", 32'(dr), 32'(e.dr));
            checkOutput("writeData", write_data, e.wData);
            checkOutput("pcLoad", 32'(pc_load), 32'(e.pcLoad));
            checkOutput("pcTarget", pc_target, e.pcTgt);
            checkOutput("err", 32'(err), 32'(e.err));
            checkOutput("latency", 32'(cycleCnt - acceptCycle), 32'(e.lat));
          end
        end else if (writeSP || writeReg || pc_load || err) begin
          checkOutput("strobeWithoutDone", 32'({writeSP, writeReg, pc_load, err}), 32'd0);
        end
      end
    end
  end

  task automatic issueOp(input logic [1:0] opc, input logic [31:0] data, input logic [31:0] pc,
                         input logic [4:0] d, input logic [31:0] sp, input logic [31:0] rdata,
                         input int waitCycles);
    int n;
    n = 0;
    op        = opc;
    push_data = data;
    pc_in     = pc;
    dr_in     = d;
    sp_in     = sp;
    mem_rdata = rdata;
    memWait   = waitCycles;
    @(negedge clk);
    while (!op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) checkOutput("opReadyTimeout", 32'(op_ready), 32'd1);
    op_valid    = 1'b1;
    acceptCycle = cycleCnt;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic drainQueue();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    expQ.delete();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] opc, input logic [31:0] data, input logic [31:0] pc,
                               input logic [4:0] d, input logic [31:0] sp, input logic [31:0] rdata,
                               input int waitCycles);
    issueOp(opc, data, pc, d, sp, rdata, waitCycles);
    drainQueue();
  endtask

  // Directed sequence.
  initial begin
    reset     = 1'b1;
    op_valid  = 1'b0;
    op        = 2'b00;
    push_data = '0;
    pc_in     = '0;
    dr_in     = '0;
    sp_in     = '0;
    mem_rdata = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstOpReady", 32'(op_ready), 32'd1);
    checkOutput("rstOutputs", 32'({readSP, writeSP, writeReg, pc_load, mem_re, mem_we, done, err}), 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // PUSH DEADBEEF at SP 0x1000, zero-wait memory.
    expQ.push_back(makeMem(1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF));
    expQ.push_back(makeWb(1'b1, 32'h0000_0FFC, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 3));
    applyStimulus(2'b00, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'h0000_1000, 32'h0, 0);

    // POP into r5 from SP 0x0FFC.
    expQ.push_back(makeMem(1'b0, 32'h0000_0FFC, 32'h0));
    expQ.push_back(makeWb(1'b1, 32'h0000_1000, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 3));
    applyStimulus(2'b01, 32'h0, 32'h0, 5'd5, 32'h0000_0FFC, 32'hDEAD_BEEF, 0);

    // CALL with return address 0x40.
    expQ.push_back(makeMem(1'b1, 32'h0000_0FFC, 32'h0000_0040));
    expQ.push_back(makeWb(1'b1, 32'h0000_0FFC, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 3));
    applyStimulus(2'b10, 32'h1111_2222, 32'h0000_0040, 5'd0, 32'h0000_1000, 32'h0, 0);

    // RET with three memory wait cycles.
    expQ.push_back(makeMem(1'b0, 32'h0000_0FFC, 32'h0));
    expQ.push_back(makeWb(1'b1, 32'h0000_1000, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 6));
    applyStimulus(2'b11, 32'h0, 32'h0, 5'd0, 32'h0000_0FFC, 32'h0000_0040, 3);

`ifdef STACK_BOUNDS_CHECK_EN
    // POP on an empty stack: underflow.
    expQ.push_back(makeWb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 2));
    applyStimulus(2'b01, 32'h0, 32'h0, 5'd7, 32'h0000_1000, 32'h1234_5678, 0);

    // PUSH at SP 0x0800 would land at 0x07FC: overflow.
    expQ.push_back(makeWb(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1, 2));
    applyStimulus(2'b00, 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0000_0800, 32'h0, 0);

    // PUSH at SP 0x0804 lands exactly on the limit: legal.
    expQ.push_back(makeMem(1'b1, 32'h0000_0800, 32'hCAFE_F00D));
    expQ.push_back(makeWb(1'b1, 32'h0000_0800, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 3));
    applyStimulus(2'b00, 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0000_0804, 32'h0, 0);
`else
    // PUSH at SP 0 wraps to the top of the address space.
    expQ.push_back(makeMem(1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A));
    expQ.push_back(makeWb(1'b1, 32'hFFFF_FFFC, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 3));
    applyStimulus(2'b00, 32'hA5A5_5A5A, 32'h0, 5'd0, 32'h0000_0000, 32'h0, 0);

    // POP at the base is not rejected without bounds checking.
    expQ.push_back(makeMem(1'b0, 32'h0000_1000, 32'h0));
    expQ.push_back(makeWb(1'b1, 32'h0000_1004, 1'b1, 5'd31, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0, 4));
    applyStimulus(2'b01, 32'h0, 32'h0, 5'd31, 32'h0000_1000, 32'h0BAD_F00D, 1);
`endif

    // Reset during the MEM phase of a PUSH whose memory never answers.
    expQ.push_back(makeMem(1'b1, 32'h0000_0FFC, 32'h1234_5678));
    issueOp(2'b00, 32'h1234_5678, 32'h0, 5'd0, 32'h0000_1000, 32'h0, 1000);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstMem", 32'({mem_we, mem_re}), 32'd0);
    checkOutput("midRstAddr", mem_addr, 32'd0);
    checkOutput("midRstStrobes", 32'({writeSP, writeReg, pc_load, done, err}), 32'd0);
    checkOutput("midRstOpReady", 32'(op_ready), 32'd1);
    checkOutput("midRstPending", 32'(expQ.size()), 32'd1);
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("postRstIdle", 32'({op_ready, writeSP, mem_we}), 32'b100);
    end

    // Normal operation resumes after the aborted push.
    expQ.push_back(makeMem(1'b1, 32'h0000_0FF8, 32'h7777_0001));
    expQ.push_back(makeWb(1'b1, 32'h0000_0FF8, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4));
    applyStimulus(2'b00, 32'h7777_0001, 32'h0, 5'd0, 32'h0000_0FFC, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
